// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush controller: stall masks,
// sequencing state encodings and the legacy bus/reset macros.
`ifndef PIPE_CTRL_DEFINES
`define PIPE_CTRL_DEFINES
`define InstAddrBus 31:0
`define ZeroWord 32'h0000_0000
`define RstEnable 1'b1
`endif

package pipe_ctrl_pkg;

    localparam int unsigned STALL_W = 6;

    // Bit 0 = PC, 1 = IF/ID, 2 = ID/EX, 3 = EX/MEM, 4 = MEM/WB, 5 = WB.
    localparam logic [STALL_W-1:0] STALL_NONE = 6'b000000;
    localparam logic [STALL_W-1:0] STALL_ID   = 6'b000111;
    localparam logic [STALL_W-1:0] STALL_EX   = 6'b001111;
    localparam logic [STALL_W-1:0] STALL_MEM  = 6'b011111;

    typedef enum logic [1:0] {
        CTRL_RUN   = 2'b00,
        CTRL_STALL = 2'b01,
        CTRL_FLUSH = 2'b10
    } ctrl_state_e;

endpackage

// File: rtl/pipe_ctrl_perf.sv
// Performance counters for pipe_ctrl: stalled cycles, flush entries and the
// longest run of consecutive cycles spent in the STALL state.
module pipe_ctrl_perf
    import pipe_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_active,
    input  logic        in_stall,
    input  logic        flush_entry,
    output logic [31:0] stall_cycles,
    output logic [15:0] flush_count,
    output logic [7:0]  max_stall_run
);

    logic [7:0] run_q;
    logic [7:0] run_inc;

    always_comb begin
        run_inc = (run_q == 8'hFF) ? 8'hFF : run_q + 8'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst == `RstEnable) begin
            stall_cycles  <= 32'd0;
            flush_count   <= 16'd0;
            max_stall_run <= 8'd0;
            run_q         <= 8'd0;
        end else begin
            if (stall_active) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
            if (flush_entry && (flush_count != 16'hFFFF)) begin
                flush_count <= flush_count + 16'd1;
            end
            if (in_stall) begin
                run_q <= run_inc;
                if (run_inc > max_stall_run) begin
                    max_stall_run <= run_inc;
                end
            end else begin
                run_q <= 8'd0;
            end
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller: combinational stall decode plus RUN/STALL/FLUSH
// sequencing with registered flush/new_pc. Define PIPE_CTRL_PERF_EN for perf counters.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               stallreq_id,
    input  logic               stallreq_ex,
    input  logic               stallreq_mem,
    input  logic               excp_req,
    input  logic [31:0]        excp_vec,
    output logic [STALL_W-1:0] stall,
    output logic               flush,
    output logic [31:0]        new_pc,
    output logic               stalling
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [31:0]        stall_cycles,
    output logic [15:0]        flush_count,
    output logic [7:0]         max_stall_run
`endif
);

    ctrl_state_e state;
    logic        any_req;

    assign any_req = stallreq_id | stallreq_ex | stallreq_mem;

    // Held in FLUSH and reset so the cleared registers are not frozen.
    always_comb begin
        stall = STALL_NONE;
        if ((rst == `RstEnable) || (state == CTRL_FLUSH)) begin
            stall = STALL_NONE;
        end else if (stallreq_mem) begin
            stall = STALL_MEM;
        end else if (stallreq_ex) begin
            stall = STALL_EX;
        end else if (stallreq_id) begin
            stall = STALL_ID;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst == `RstEnable) begin
            state    <= CTRL_RUN;
            flush    <= 1'b0;
            new_pc   <= `ZeroWord;
            stalling <= 1'b0;
        end else begin
            case (state)
                CTRL_FLUSH: begin
                    state    <= CTRL_RUN;
                    flush    <= 1'b0;
                    stalling <= 1'b0;
                end
                default: begin
                    if (excp_req) begin
                        state    <= CTRL_FLUSH;
                        flush    <= 1'b1;
                        new_pc   <= excp_vec;
                        stalling <= 1'b0;
                    end else if (any_req) begin
                        state    <= CTRL_STALL;
                        flush    <= 1'b0;
                        stalling <= 1'b1;
                    end else begin
                        state    <= CTRL_RUN;
                        flush    <= 1'b0;
                        stalling <= 1'b0;
                    end
                end
            endcase
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    pipe_ctrl_perf u_perf (
        .clk           (clk),
        .rst           (rst),
        .stall_active  (|stall),
        .in_stall      (state == CTRL_STALL),
        .flush_entry   ((state != CTRL_FLUSH) && excp_req),
        .stall_cycles  (stall_cycles),
        .flush_count   (flush_count),
        .max_stall_run (max_stall_run)
    );
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: per-cycle expectations from a rule-level model,
// checked by an independent negedge monitor; plus direct async-reset checks.
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        stallreq_id, stallreq_ex, stallreq_mem, excp_req;
    logic [31:0] excp_vec;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        stalling;
`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] stall_cycles;
    logic [15:0] flush_count;
    logic [7:0]  max_stall_run;
`endif

    pipe_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .stallreq_id  (stallreq_id),
        .stallreq_ex  (stallreq_ex),
        .stallreq_mem (stallreq_mem),
        .excp_req     (excp_req),
        .excp_vec     (excp_vec),
        .stall        (stall),
        .flush        (flush),
        .new_pc       (new_pc),
        .stalling     (stalling)
`ifdef PIPE_CTRL_PERF_EN
        ,
        .stall_cycles  (stall_cycles),
        .flush_count   (flush_count),
        .max_stall_run (max_stall_run)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  stall;
        logic        flush;
        logic [31:0] new_pc;
        logic        stalling;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Model: an exception seen outside a flush cycle produces flush next cycle;
    // any request seen outside a flush cycle (and without exception) means stalling next cycle.
    logic        m_flush, m_stalling;
    logic [31:0] m_pc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        m_flush    = 1'b0;
        m_stalling = 1'b0;
        m_pc       = 32'h0;
    endtask

    function automatic logic [5:0] mask_of(input logic id, input logic ex, input logic mem);
        if (mem) return 6'd31;
        if (ex)  return 6'd15;
        if (id)  return 6'd7;
        return 6'd0;
    endfunction

    task automatic drive_cycle(input logic id, input logic ex, input logic mem,
                               input logic excp, input logic [31:0] vec);
        exp_t e;
        @(posedge clk);
        #1;
        stallreq_id  = id;
        stallreq_ex  = ex;
        stallreq_mem = mem;
        excp_req     = excp;
        excp_vec     = vec;
        e.flush    = m_flush;
        e.new_pc   = m_pc;
        e.stalling = m_stalling;
        e.stall    = m_flush ? 6'd0 : mask_of(id, ex, mem);
        exp_q.push_back(e);
        if (m_flush) begin
            m_flush    = 1'b0;
            m_stalling = 1'b0;
        end else if (excp) begin
            m_flush    = 1'b1;
            m_pc       = vec;
            m_stalling = 1'b0;
        end else begin
            m_stalling = id | ex | mem;
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("stall",    {26'd0, stall}, {26'd0, e.stall});
            check("flush",    {31'd0, flush}, {31'd0, e.flush});
            check("new_pc",   new_pc, e.new_pc);
            check("stalling", {31'd0, stalling}, {31'd0, e.stalling});
        end
    end

    // Assert rst between edges with a live stall request and check outputs at once.
    task automatic async_reset_check(input string tag);
        @(negedge clk);
        #2;
        stallreq_mem = 1'b1;
        rst = 1'b1;
        #1;
        check({tag, "_stall"},    {26'd0, stall}, 32'd0);
        check({tag, "_flush"},    {31'd0, flush}, 32'd0);
        check({tag, "_new_pc"},   new_pc, 32'd0);
        check({tag, "_stalling"}, {31'd0, stalling}, 32'd0);
`ifdef PIPE_CTRL_PERF_EN
        check({tag, "_stall_cycles"}, stall_cycles, 32'd0);
        check({tag, "_flush_count"}, {16'd0, flush_count}, 32'd0);
        check({tag, "_max_run"}, {24'd0, max_stall_run}, 32'd0);
`endif
        @(posedge clk);
        #2;
        stallreq_id = 1'b0; stallreq_ex = 1'b0; stallreq_mem = 1'b0;
        excp_req = 1'b0; excp_vec = 32'h0;
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        rst = 1'b1;
        stallreq_id = 1'b0; stallreq_ex = 1'b0; stallreq_mem = 1'b0;
        excp_req = 1'b0; excp_vec = 32'h0;
        model_reset();
        #12 rst = 1'b0;

        // Priority: id+ex together, then mem alone.
        drive_cycle(1, 1, 0, 0, 32'h0);
        drive_cycle(0, 0, 1, 0, 32'h0);
        drive_cycle(0, 0, 0, 0, 32'h0);
        drive_cycle(0, 0, 0, 0, 32'h0);

        // Exception redirect from RUN.
        drive_cycle(0, 0, 0, 1, 32'h0000_0020);
        drive_cycle(0, 0, 0, 0, 32'h0);
        drive_cycle(0, 0, 0, 0, 32'h0);

        // Exception held three cycles during a memory stall.
        repeat (3) drive_cycle(0, 0, 1, 1, 32'h0000_0040);
        drive_cycle(0, 0, 0, 0, 32'h0);
        drive_cycle(0, 0, 0, 0, 32'h0);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            drive_cycle($urandom_range(0, 9) < 3, $urandom_range(0, 9) < 3,
                        $urandom_range(0, 9) < 3, $urandom_range(0, 9) == 0, $urandom);
        end

        // Reset mid-stall.
        drive_cycle(0, 0, 1, 0, 32'h0);
        drive_cycle(0, 0, 1, 0, 32'h0);
        async_reset_check("rst_stall");
        drive_cycle(0, 0, 0, 0, 32'h0);

        // Reset mid-flush: second cycle is the flush cycle.
        drive_cycle(0, 0, 0, 1, 32'h1234_5678);
        drive_cycle(0, 0, 0, 1, 32'h1234_5678);
        async_reset_check("rst_flush");
        repeat (3) drive_cycle(0, 0, 0, 0, 32'h0);

`ifdef PIPE_CTRL_PERF_EN
        async_reset_check("rst_perf");
        repeat (5) drive_cycle(0, 1, 0, 0, 32'h0);
        repeat (2) drive_cycle(0, 0, 0, 0, 32'h0);
        repeat (3) drive_cycle(1, 0, 0, 0, 32'h0);
        drive_cycle(0, 0, 0, 1, 32'h0000_0080);
        repeat (3) drive_cycle(0, 0, 0, 0, 32'h0);
        @(negedge clk);
        check("perf_stall_cycles", stall_cycles, 32'd8);
        check("perf_max_stall_run", {24'd0, max_stall_run}, 32'd5);
        check("perf_flush_count", {16'd0, flush_count}, 32'd1);
`endif

        repeat (2) @(posedge clk);
        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
